// File: rtl/nlp_update_scheduler.sv
// NLP table update scheduler.
// Two requesters (backend and IF3) queue predictor updates in private FIFOs;
// a two-state FSM first sweeps the table clear, then retires at most one
// queued update per cycle with a backend-first, starvation-bounded arbiter.

// Small synchronous FIFO used for each requester queue.
module nlp_usched_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    assign o_data  = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));

    // Storage array: written on push, no reset needed for payload.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wp <= (r_wp == LAST_PTR) ? '0 : r_wp + AW'(1);
            end
            if (i_pop) begin
                r_rp <= (r_rp == LAST_PTR) ? '0 : r_rp + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module nlp_update_scheduler #(
    parameter int unsigned NLP_SIZE     = 16,
    parameter int unsigned IDX_W        = $clog2(NLP_SIZE),
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             be_valid,
    output logic             be_ready,
    input  logic [31:0]      be_pc,
    input  logic [31:0]      be_target,
    input  logic             be_taken,
    input  logic [1:0]       be_bim,
    input  logic             f3_valid,
    output logic             f3_ready,
    input  logic [31:0]      f3_pc,
    input  logic [31:0]      f3_target,
    input  logic             f3_taken,
    input  logic [1:0]       f3_bim,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic [31:0]      wr_target,
    output logic [1:0]       wr_bim,
    output logic             wr_vbit,
    output logic             busy_clear,
    output logic [15:0]      drop_cnt
);
    // Queue entry: {index, target, taken, prior bimodal}
    localparam int unsigned EW = IDX_W + 35;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLP_SIZE - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [SW-1:0]    r_starve;
    logic [15:0]      r_drop;

    logic          w_run;
    logic          w_act;
    logic          w_be_push, w_f3_push;
    logic          w_be_pop, w_f3_pop;
    logic          w_be_empty, w_f3_empty;
    logic          w_be_full, w_f3_full;
    logic          w_be_ne, w_f3_ne;
    logic [EW-1:0] w_be_din, w_f3_din;
    logic [EW-1:0] w_be_dout, w_f3_dout;
    logic [IDX_W-1:0] w_be_idx, w_f3_idx;
    logic          w_force;
    logic          w_grant_be, w_grant_f3;
    logic          w_drop;
    logic          w_pc_unused;

    function automatic logic [1:0] bim_next(input logic tk, input logic [1:0] b);
        if (tk) begin
            return (b == 2'b11) ? 2'b11 : b + 2'd1;
        end else begin
            return (b == 2'b00) ? 2'b00 : b - 2'd1;
        end
    endfunction

    assign w_pc_unused = ^{be_pc[31:IDX_W+2], be_pc[1:0], f3_pc[31:IDX_W+2], f3_pc[1:0]};

    assign w_run = (r_state == RUN);
    // Writes and pops only happen in RUN outside reset; a flush kills the cycle.
    assign w_act = rst & w_run & ~flush;

    assign be_ready   = rst & w_run & ~w_be_full;
    assign f3_ready   = rst & w_run & ~w_f3_full;
    assign busy_clear = ~rst | (r_state == CLEAR);
    assign drop_cnt   = r_drop;

    assign w_be_push = be_valid & be_ready & ~flush;
    assign w_f3_push = f3_valid & f3_ready & ~flush;

    assign w_be_din = {be_pc[IDX_W+1:2], be_target, be_taken, be_bim};
    assign w_f3_din = {f3_pc[IDX_W+1:2], f3_target, f3_taken, f3_bim};

    assign w_be_ne  = ~w_be_empty;
    assign w_f3_ne  = ~w_f3_empty;
    assign w_be_idx = w_be_dout[EW-1 -: IDX_W];
    assign w_f3_idx = w_f3_dout[EW-1 -: IDX_W];

    assign w_force    = w_f3_ne & (r_starve == SW'(STARVE_LIMIT));
    assign w_grant_f3 = w_f3_ne & (~w_be_ne | w_force);
    assign w_grant_be = w_be_ne & ~w_grant_f3;
    // A same-index IF3 head loses to the backend write and is discarded.
    assign w_drop     = w_grant_be & w_f3_ne & (w_be_idx == w_f3_idx);

    assign w_be_pop = w_act & w_grant_be;
    assign w_f3_pop = w_act & (w_grant_f3 | w_drop);

    nlp_usched_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_be_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (flush),
        .i_push  (w_be_push),
        .i_data  (w_be_din),
        .i_pop   (w_be_pop),
        .o_data  (w_be_dout),
        .o_empty (w_be_empty),
        .o_full  (w_be_full)
    );

    nlp_usched_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_f3_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (flush),
        .i_push  (w_f3_push),
        .i_data  (w_f3_din),
        .i_pop   (w_f3_pop),
        .o_data  (w_f3_dout),
        .o_empty (w_f3_empty),
        .o_full  (w_f3_full)
    );

    // FSM, sweep counter, starvation counter and drop counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= CLEAR;
            r_sweep  <= '0;
            r_starve <= '0;
            r_drop   <= '0;
        end else if (flush) begin
            r_state  <= CLEAR;
            r_sweep  <= '0;
            r_starve <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_starve <= '0;
                    if (r_sweep == LAST_IDX) begin
                        r_state <= RUN;
                        r_sweep <= '0;
                    end else begin
                        r_sweep <= r_sweep + IDX_W'(1);
                    end
                end
                RUN: begin
                    if (!w_f3_ne || w_grant_f3) begin
                        r_starve <= '0;
                    end else begin
                        r_starve <= r_starve + SW'(1);
                    end
                    if (w_drop && (r_drop != '1)) begin
                        r_drop <= r_drop + 16'd1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_sweep <= '0;
                end
            endcase
        end
    end

    // Table write port: sweep clears in CLEAR, granted head in RUN.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_target = '0;
        wr_bim    = 2'b00;
        wr_vbit   = 1'b0;
        if (rst && (r_state == CLEAR)) begin
            wr_en  = 1'b1;
            wr_idx = r_sweep;
            wr_bim = 2'b01;
        end else if (w_act && w_grant_f3) begin
            wr_en     = 1'b1;
            wr_vbit   = 1'b1;
            wr_idx    = w_f3_idx;
            wr_target = w_f3_dout[34:3];
            wr_bim    = bim_next(w_f3_dout[2], w_f3_dout[1:0]);
        end else if (w_act && w_grant_be) begin
            wr_en     = 1'b1;
            wr_vbit   = 1'b1;
            wr_idx    = w_be_idx;
            wr_target = w_be_dout[34:3];
            wr_bim    = bim_next(w_be_dout[2], w_be_dout[1:0]);
        end
    end
endmodule

// File: tb/tb_nlp_update_scheduler.sv
// Directed self-checking bench for nlp_update_scheduler (NLP_SIZE=16).
module tb_nlp_update_scheduler;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        be_valid, be_ready, be_taken;
    logic [31:0] be_pc, be_target;
    logic [1:0]  be_bim;
    logic        f3_valid, f3_ready, f3_taken;
    logic [31:0] f3_pc, f3_target;
    logic [1:0]  f3_bim;
    logic        wr_en, wr_vbit, busy_clear;
    logic [3:0]  wr_idx;
    logic [31:0] wr_target;
    logic [1:0]  wr_bim;
    logic [15:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        src;   // 0 = backend, 1 = IF3
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic [1:0]  bim;
        logic [3:0]  eidx;
        logic [1:0]  ebim;
    } vec_t;

    vec_t vecs [8];

    nlp_update_scheduler #(
        .NLP_SIZE     (16),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .be_valid   (be_valid),
        .be_ready   (be_ready),
        .be_pc      (be_pc),
        .be_target  (be_target),
        .be_taken   (be_taken),
        .be_bim     (be_bim),
        .f3_valid   (f3_valid),
        .f3_ready   (f3_ready),
        .f3_pc      (f3_pc),
        .f3_target  (f3_target),
        .f3_taken   (f3_taken),
        .f3_bim     (f3_bim),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_target  (wr_target),
        .wr_bim     (wr_bim),
        .wr_vbit    (wr_vbit),
        .busy_clear (busy_clear),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Full observable write/status bundle
    function automatic logic [42:0] obs();
        return {wr_en, wr_vbit, wr_idx, wr_target, wr_bim, busy_clear, be_ready, f3_ready};
    endfunction

    function automatic logic [42:0] ex(input logic en, input logic v, input logic [3:0] idx,
                                       input logic [31:0] tgt, input logic [1:0] bim,
                                       input logic busy, input logic br, input logic fr);
        return {en, v, idx, tgt, bim, busy, br, fr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_be(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic [1:0] bim);
        be_valid = 1'b1; be_pc = pc; be_target = tgt; be_taken = tk; be_bim = bim;
    endtask

    task automatic drive_f3(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic [1:0] bim);
        f3_valid = 1'b1; f3_pc = pc; f3_target = tgt; f3_taken = tk; f3_bim = bim;
    endtask

    // Checks a complete 16-entry clear sweep starting in the current cycle.
    task automatic sweep(input string nm);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_idx%0d", nm, i), 64'(obs()),
                64'(ex(1'b1, 1'b0, 4'(i), 32'h0, 2'b01, 1'b1, 1'b0, 1'b0)));
            tick();
        end
        chk({nm, "_run"}, 64'({busy_clear, be_ready, f3_ready, wr_en}), 64'(4'b0110));
    endtask

    task automatic idle_cycles(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            chk(nm, 64'(wr_en), 64'(1'b0));
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0000_1000, 1'b1, 2'd3, 4'h0, 2'd3};
        vecs[1] = '{1'b0, 32'h0000_0044, 32'h0000_2222, 1'b0, 2'd0, 4'h1, 2'd0};
        vecs[2] = '{1'b0, 32'h0000_003C, 32'h0000_3333, 1'b1, 2'd1, 4'hF, 2'd2};
        vecs[3] = '{1'b0, 32'h0000_0108, 32'h0000_4444, 1'b0, 2'd2, 4'h2, 2'd1};
        vecs[4] = '{1'b1, 32'h0000_007C, 32'h0000_5555, 1'b1, 2'd2, 4'hF, 2'd3};
        vecs[5] = '{1'b1, 32'h0000_0024, 32'h0000_6666, 1'b0, 2'd1, 4'h9, 2'd0};
        vecs[6] = '{1'b1, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 1'b0, 2'd3, 4'hC, 2'd2};
        vecs[7] = '{1'b0, 32'h1234_5678, 32'hCAFE_F00D, 1'b1, 2'd0, 4'hE, 2'd1};

        rst = 1'b0; flush = 1'b0;
        be_valid = 1'b0; be_pc = '0; be_target = '0; be_taken = 1'b0; be_bim = '0;
        f3_valid = 1'b0; f3_pc = '0; f3_target = '0; f3_taken = 1'b0; f3_bim = '0;

        // Reset state
        tick();
        tick();
        chk("rst_out", 64'({wr_en, be_ready, f3_ready, busy_clear}), 64'(4'b0001));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        rst = 1'b1;
        #1;
        sweep("init");

        // Single requests through an otherwise idle scheduler
        foreach (vecs[v]) begin
            if (vecs[v].src) drive_f3(vecs[v].pc, vecs[v].tgt, vecs[v].tk, vecs[v].bim);
            else             drive_be(vecs[v].pc, vecs[v].tgt, vecs[v].tk, vecs[v].bim);
            #1;
            chk($sformatf("vec%0d_ready", v), 64'(vecs[v].src ? f3_ready : be_ready), 64'(1'b1));
            tick();
            be_valid = 1'b0; f3_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_wr", v), 64'(obs()),
                64'(ex(1'b1, 1'b1, vecs[v].eidx, vecs[v].tgt, vecs[v].ebim, 1'b0, 1'b1, 1'b1)));
            tick();
            chk($sformatf("vec%0d_idle", v), 64'(wr_en), 64'(1'b0));
        end

        // Starvation: backend every cycle, IF3 head waits exactly 4 cycles
        drive_f3(32'h44, 32'h0000_F3F3, 1'b1, 2'd1);
        drive_be(32'h80, 32'h0000_BEBE, 1'b0, 2'd2);
        tick();
        f3_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            if (k < 5) begin
                chk($sformatf("starve_be%0d", k), 64'({wr_en, wr_idx, wr_target, wr_bim}),
                    64'({1'b1, 4'h0, 32'h0000_BEBE, 2'd1}));
            end else begin
                chk("starve_f3", 64'({wr_en, wr_vbit, wr_idx, wr_target, wr_bim}),
                    64'({1'b1, 1'b1, 4'h1, 32'h0000_F3F3, 2'd2}));
                be_valid = 1'b0;
            end
            tick();
        end
        chk("starve_be_tail", 64'({wr_en, wr_target}), 64'({1'b1, 32'h0000_BEBE}));
        tick();
        idle_cycles("starve_idle", 1);

        // Same-index conflict with backend granted: IF3 head dropped
        drive_be(32'h48, 32'h0000_00B0, 1'b1, 2'd1);
        drive_f3(32'h48, 32'h0000_00F0, 1'b0, 2'd1);
        tick();
        be_valid = 1'b0; f3_valid = 1'b0;
        #1;
        chk("drop_wr", 64'({wr_en, wr_vbit, wr_idx, wr_target, wr_bim}),
            64'({1'b1, 1'b1, 4'h2, 32'h0000_00B0, 2'd2}));
        tick();
        chk("drop_idle", 64'(wr_en), 64'(1'b0));
        chk("drop_cnt1", 64'(drop_cnt), 64'(1));

        // Forced IF3 grant on a same-index conflict keeps the backend head
        drive_f3(32'h50, 32'h0000_00F4, 1'b1, 2'd0);
        drive_be(32'h80, 32'h0000_00B0, 1'b0, 2'd1);
        tick();
        f3_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) drive_be(32'h150, 32'h0000_00B4, 1'b1, 2'd1);
            #1;
            chk($sformatf("force_be%0d", k), 64'({wr_en, wr_idx, wr_target}),
                64'({1'b1, 4'h0, 32'h0000_00B0}));
            tick();
        end
        be_valid = 1'b0;
        #1;
        chk("force_f3", 64'({wr_en, wr_vbit, wr_idx, wr_target, wr_bim}),
            64'({1'b1, 1'b1, 4'h4, 32'h0000_00F4, 2'd1}));
        tick();
        chk("force_be_kept", 64'({wr_en, wr_vbit, wr_idx, wr_target, wr_bim}),
            64'({1'b1, 1'b1, 4'h4, 32'h0000_00B4, 2'd2}));
        tick();
        chk("force_idle", 64'(wr_en), 64'(1'b0));
        chk("force_drop", 64'(drop_cnt), 64'(1));

        // Flush with queued entries plus a request on the flush cycle
        drive_be(32'h60, 32'h0000_00A1, 1'b1, 2'd1);
        drive_f3(32'h64, 32'h0000_00A2, 1'b1, 2'd1);
        tick();
        drive_be(32'h68, 32'h0000_00A3, 1'b1, 2'd1);
        drive_f3(32'h6C, 32'h0000_00A4, 1'b1, 2'd1);
        #1;
        chk("fl_first", 64'({wr_en, wr_target}), 64'({1'b1, 32'h0000_00A1}));
        tick();
        f3_valid = 1'b0;
        drive_be(32'h70, 32'h0000_00DD, 1'b1, 2'd1);
        flush = 1'b1;
        #1;
        chk("fl_f3_full", 64'({be_ready, f3_ready}), 64'(2'b10));
        chk("fl_no_wr", 64'(wr_en), 64'(1'b0));
        tick();
        flush = 1'b0; be_valid = 1'b0;
        #1;
        // Flush during CLEAR at idx 5 restarts the sweep
        for (int i = 0; i <= 5; i++) begin
            chk($sformatf("fl_part%0d", i), 64'(obs()),
                64'(ex(1'b1, 1'b0, 4'(i), 32'h0, 2'b01, 1'b1, 1'b0, 1'b0)));
            if (i == 5) flush = 1'b1;
            tick();
        end
        flush = 1'b0;
        #1;
        sweep("fl_restart");
        idle_cycles("fl_lost", 4);

        // Reset for one cycle at sweep index 7
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) tick();
        chk("rmid_idx7", 64'({wr_en, wr_idx}), 64'({1'b1, 4'h7}));
        rst = 1'b0;
        #1;
        chk("rmid_out", 64'({wr_en, be_ready, f3_ready, busy_clear}), 64'(4'b0001));
        tick();
        rst = 1'b1;
        #1;
        chk("rmid_drop", 64'(drop_cnt), 64'(0));
        sweep("rmid");

        // Reset in RUN abandons queued updates
        drive_be(32'h20, 32'h0000_0C01, 1'b1, 2'd1);
        drive_f3(32'h24, 32'h0000_0C02, 1'b1, 2'd1);
        tick();
        be_valid = 1'b0; f3_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rrun_out", 64'({wr_en, be_ready, f3_ready, busy_clear}), 64'(4'b0001));
        tick();
        rst = 1'b1;
        #1;
        sweep("rrun");
        idle_cycles("rrun_lost", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
